// File: rtl/ram16k_arbiter_if.sv
// Requester-side bus of ram16k_arbiter: request/grant/response channels for
// the primary requester A (CPU) and the secondary requester B (DMA/screen).
interface ram16k_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata
  );
endinterface

// File: rtl/ram16k_arbiter.sv
// Two-requester arbiter/sequencer for RAM16K: grant -> command -> issue -> response.
// Define RAM16K_ARB_FIXED_PRIO_EN for fixed A-over-B priority (default: round-robin).
module ram16k_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  ram16k_arbiter_if.slave   bus,
  output logic              ram_load,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  logic              a_wins;
  logic              a_gnt;
  logic              b_gnt;

  logic              cmd_valid;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  owner_e            cmd_owner;

  logic              a_rvalid_q;
  logic              b_rvalid_q;
  logic [DATA_W-1:0] rdata_q;

`ifdef RAM16K_ARB_FIXED_PRIO_EN
  assign a_wins = 1'b1;
`else
  owner_e last;

  // Reset to B so that A wins the first contention after reset.
  always_ff @(posedge clk) begin
    if (!rst_n)     last <= OWN_B;
    else if (a_gnt) last <= OWN_A;
    else if (b_gnt) last <= OWN_B;
  end

  assign a_wins = (last == OWN_B);
`endif

  // Grants are masked by rst_n so nothing is accepted while reset is held.
  assign a_gnt = rst_n & bus.a_req & (~bus.b_req | a_wins);
  assign b_gnt = rst_n & bus.b_req & ~a_gnt;

  assign bus.a_gnt = a_gnt;
  assign bus.b_gnt = b_gnt;

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the previous-cycle value of the stage before it, giving a true pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset as well because ram_address, ram_in
      // and rdata must come out of reset at zero, not at whatever was last held.
      cmd_valid  <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cmd_owner  <= OWN_A;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      cmd_valid <= a_gnt | b_gnt;
      if (a_gnt) begin
        cmd_we    <= bus.a_we;
        cmd_addr  <= bus.a_addr;
        cmd_wdata <= bus.a_wdata;
        cmd_owner <= OWN_A;
      end else if (b_gnt) begin
        cmd_we    <= bus.b_we;
        cmd_addr  <= bus.b_addr;
        cmd_wdata <= bus.b_wdata;
        cmd_owner <= OWN_B;
      end

      // Capture the RAM's combinational read at the end of the issue cycle.
      a_rvalid_q <= cmd_valid & ~cmd_we & (cmd_owner == OWN_A);
      b_rvalid_q <= cmd_valid & ~cmd_we & (cmd_owner == OWN_B);
      if (cmd_valid && !cmd_we) rdata_q <= ram_out;
    end
  end

  // Address/data hold their last command when idle; only load is qualified.
  assign ram_load    = cmd_valid & cmd_we;
  assign ram_address = cmd_addr;
  assign ram_in      = cmd_wdata;

  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.a_rdata  = rdata_q;
  assign bus.b_rdata  = rdata_q;

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Self-checking bench for ram16k_arbiter: RAM16K model, transaction-level
// reference model checked every cycle, plus directed literal expectations.
module tb_ram16k_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  logic              clk;
  logic              rst_n;
  logic              ram_load;
  logic [DATA_W-1:0] ram_in;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_out;

  ram16k_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram16k_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .ram_load    (ram_load),
    .ram_in      (ram_in),
    .ram_address (ram_address),
    .ram_out     (ram_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM16K: combinational read, write on rising edge.
  logic [DATA_W-1:0] mem [0:16383];
  assign ram_out = mem[ram_address];
  always @(posedge clk) if (ram_load === 1'b1) mem[ram_address] <= ram_in;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int                due;
    bit                own_b;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic [DATA_W-1:0] shadow [0:16383];
  rsp_t              rsp_q[$];
  int                cyc = 0;
  bit                started = 1'b0;
  bit                m_prev_b = 1'b1;
  bit                m_iss_valid = 1'b0;
  bit                m_iss_we = 1'b0;
  logic [ADDR_W-1:0] m_iss_addr = '0;
  logic [DATA_W-1:0] m_iss_wdata = '0;
  logic [DATA_W-1:0] m_rdata = '0;
  bit                e_ga, e_gb, e_ra, e_rb;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      if (!rst_n) begin
        e_ga = 1'b0;
        e_gb = 1'b0;
      end else if (bus.a_req && bus.b_req) begin
`ifdef RAM16K_ARB_FIXED_PRIO_EN
        e_ga = 1'b1;
`else
        e_ga = m_prev_b;
`endif
        e_gb = !e_ga;
      end else begin
        e_ga = bus.a_req;
        e_gb = bus.b_req;
      end
      check("a_gnt", bus.a_gnt, e_ga);
      check("b_gnt", bus.b_gnt, e_gb);

      check("ram_load", ram_load, m_iss_valid && m_iss_we);
      if (m_iss_valid) check("ram_address", ram_address, m_iss_addr);
      if (m_iss_valid && m_iss_we) check("ram_in", ram_in, m_iss_wdata);

      e_ra = 1'b0;
      e_rb = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        e_ra    = !rsp_q[0].own_b;
        e_rb    = rsp_q[0].own_b;
        m_rdata = rsp_q[0].data;
        void'(rsp_q.pop_front());
      end
      check("a_rvalid", bus.a_rvalid, e_ra);
      check("b_rvalid", bus.b_rvalid, e_rb);
      check("a_rdata", bus.a_rdata, m_rdata);
      check("b_rdata", bus.b_rdata, m_rdata);

      // Accesses take effect in grant order; a reset drops pending responses.
      if (!rst_n) begin
        rsp_q.delete();
        m_prev_b    = 1'b1;
        m_iss_valid = 1'b0;
        m_iss_addr  = '0;
        m_rdata     = '0;
      end else if (e_ga || e_gb) begin
        m_prev_b    = e_gb;
        m_iss_valid = 1'b1;
        m_iss_we    = e_ga ? bus.a_we    : bus.b_we;
        m_iss_addr  = e_ga ? bus.a_addr  : bus.b_addr;
        m_iss_wdata = e_ga ? bus.a_wdata : bus.b_wdata;
        if (m_iss_we) shadow[m_iss_addr] = m_iss_wdata;
        else rsp_q.push_back('{due: cyc + 2, own_b: e_gb, data: shadow[m_iss_addr]});
      end else begin
        m_iss_valid = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit rst, input bit ar, input bit aw, input logic [ADDR_W-1:0] aa,
                       input logic [DATA_W-1:0] ad, input bit br, input bit bw,
                       input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
    @(posedge clk);
    #1;
    rst_n       = rst;
    bus.a_req   = ar;
    bus.a_we    = aw;
    bus.a_addr  = aa;
    bus.a_wdata = ad;
    bus.b_req   = br;
    bus.b_we    = bw;
    bus.b_addr  = ba;
    bus.b_wdata = bd;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    mem[5]    = 16'h0005;
    mem[6]    = 16'h0006;
    shadow[5] = 16'h0005;
    shadow[6] = 16'h0006;

    // Reset held 3 cycles with both requesters asking.
    rst_n       = 1'b0;
    bus.a_req   = 1'b1;
    bus.a_we    = 1'b0;
    bus.a_addr  = 14'd1;
    bus.a_wdata = '0;
    bus.b_req   = 1'b1;
    bus.b_we    = 1'b0;
    bus.b_addr  = 14'd2;
    bus.b_wdata = '0;
    repeat (3) begin
      @(posedge clk);
      #2;
      check("rst a_gnt", bus.a_gnt, 0);
      check("rst b_gnt", bus.b_gnt, 0);
      check("rst ram_load", ram_load, 0);
    end
    check("rst ram_address", ram_address, 0);
    check("rst ram_in", ram_in, 0);
    check("rst a_rvalid", bus.a_rvalid, 0);
    check("rst b_rvalid", bus.b_rvalid, 0);
    check("rst a_rdata", bus.a_rdata, 0);

    // Contention: A reads 5, B reads 6, both requesting for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 14'd5, '0, 1'b1, 1'b0, 14'd6, '0);
      #2;
`ifdef RAM16K_ARB_FIXED_PRIO_EN
      check("cont a_gnt", bus.a_gnt, 1);
      check("cont b_gnt", bus.b_gnt, 0);
`else
      check("cont a_gnt", bus.a_gnt, (i % 2 == 0) ? 1 : 0);
      check("cont b_gnt", bus.b_gnt, (i % 2 == 0) ? 0 : 1);
`endif
      if (i == 2) begin
        check("cont a_rvalid", bus.a_rvalid, 1);
        check("cont a_rdata", bus.a_rdata, 16'h0005);
      end
    end
    idle();
    idle();
    idle();

    // A writes 0x1234 to 100, then reads it back.
    drive(1'b1, 1'b1, 1'b1, 14'd100, 16'h1234, 1'b0, 1'b0, '0, '0);
    #2;
    check("wr a_gnt", bus.a_gnt, 1);
    drive(1'b1, 1'b1, 1'b0, 14'd100, '0, 1'b0, 1'b0, '0, '0);
    #2;
    check("wr ram_load", ram_load, 1);
    check("wr ram_address", ram_address, 100);
    check("wr ram_in", ram_in, 16'h1234);
    idle();
    idle();
    #2;
    check("rd a_rvalid", bus.a_rvalid, 1);
    check("rd a_rdata", bus.a_rdata, 16'h1234);

    // Boundary address: B writes 0xFFFF to 16383, then reads it.
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 14'd16383, 16'hFFFF);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 14'd16383, '0);
    idle();
    idle();
    #2;
    check("bnd b_rvalid", bus.b_rvalid, 1);
    check("bnd b_rdata", bus.b_rdata, 16'hFFFF);
    check("bnd mem0", mem[0], 0);
    check("bnd mem16383", mem[16383], 16'hFFFF);

    // Reset while an A read is in the issue stage.
    drive(1'b1, 1'b1, 1'b0, 14'd100, '0, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    idle();
    #2;
    check("mrst a_rvalid", bus.a_rvalid, 0);
    check("mrst ram_load", ram_load, 0);
    idle();
    #2;
    check("mrst a_rvalid2", bus.a_rvalid, 0);
    check("mrst mem100", mem[100], 16'h1234);

    // Back-to-back read-after-write at address 42.
    drive(1'b1, 1'b1, 1'b1, 14'd42, 16'd7, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 1'b0, 14'd42, '0, 1'b0, 1'b0, '0, '0);
    idle();
    idle();
    #2;
    check("raw a_rvalid", bus.a_rvalid, 1);
    check("raw a_rdata", bus.a_rdata, 16'd7);
    repeat (3) idle();

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
